// File: rtl/jt49_dcrm_mc.sv
// jt49_dcrm_mc: time-multiplexed per-channel DC removal by moving-average subtraction
module jt49_dcrm_mc #(
    parameter int W        = 8,
    parameter int CH       = 3,
    parameter int DEPTHLOG = 4,
    localparam int CW      = CH > 1 ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          din_valid,
    input  logic [CW-1:0] din_ch,
    input  logic [W-1:0]  din,
    input  logic          bypass,
    input  logic          flush,
    output logic          din_ready,
    output logic          dout_valid,
    output logic [CW-1:0] dout_ch,
    output logic [W:0]    dout
);
    localparam int N  = 1 << DEPTHLOG;
    localparam int SW = W + DEPTHLOG;
    localparam int HN = CH * N;
    localparam int FW = $clog2(HN);

    typedef enum logic [2:0] {IDLE, READ, UPDATE, OUT, FLUSH} state_t;

    state_t                st, nx;
    logic [CW-1:0]         ch, idx;
    logic [W-1:0]          din_r, old, avg;
    logic                  byp, ch_ok;
    logic [W-1:0]          hist [HN];
    logic [SW-1:0]         sum  [CH];
    logic [DEPTHLOG-1:0]   ptr  [CH];
    logic [FW-1:0]         fcnt, hidx;
    logic [SW-1:0]         sum_new;
    logic [W:0]            dout_n;

    // Decode the registered channel; an out-of-range index is clamped so no array is over-indexed
    always_comb begin
        ch_ok   = 32'(ch) < CH;
        idx     = ch_ok ? ch : '0;
        hidx    = FW'(32'(idx) * N + 32'(ptr[idx]));
        sum_new = sum[idx] + SW'(din_r) - SW'(old);
        avg     = W'(sum[idx] >> DEPTHLOG);
        dout_n  = byp ? {1'b0, din_r} : {1'b0, din_r} - {1'b0, avg};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= IDLE;
        else if (cen)
            st <= nx;
    end

    // Next-state logic; flush wins over a simultaneous sample offer
    always_comb begin
        nx = st;
        case (st)
            IDLE:    nx = flush ? FLUSH : din_valid ? READ : IDLE;
            READ:    nx = ch_ok ? UPDATE : IDLE;
            UPDATE:  nx = OUT;
            OUT:     nx = IDLE;
            FLUSH:   nx = fcnt == FW'(HN - 1) ? IDLE : FLUSH;
            default: nx = IDLE;
        endcase
    end

    // Output logic
    always_comb din_ready = st == IDLE && !flush;

    // Datapath: capture, history read, running-sum update, result register and flush sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch         <= '0;
            din_r      <= '0;
            byp        <= 1'b0;
            old        <= '0;
            fcnt       <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < HN; i++) hist[i] <= '0;
            for (int i = 0; i < CH; i++) begin
                sum[i] <= '0;
                ptr[i] <= '0;
            end
        end else if (cen) begin
            dout_valid <= st == OUT;
            case (st)
                IDLE: begin
                    fcnt <= '0;
                    if (din_valid && !flush) begin
                        ch    <= din_ch;
                        din_r <= din;
                        byp   <= bypass;
                    end
                end
                READ:   old <= hist[hidx];
                UPDATE: begin
                    sum[idx]   <= sum_new;
                    hist[hidx] <= din_r;
                    ptr[idx]   <= ptr[idx] + 1'b1;
                end
                OUT: begin
                    dout    <= dout_n;
                    dout_ch <= ch;
                end
                FLUSH: begin
                    hist[fcnt] <= '0;
                    fcnt       <= fcnt + 1'b1;
                    if (fcnt == FW'(HN - 1))
                        for (int i = 0; i < CH; i++) begin
                            sum[i] <= '0;
                            ptr[i] <= '0;
                        end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt49_dcrm_mc.sv
// tb_jt49_dcrm_mc: directed-vector bench for jt49_dcrm_mc with W=8, CH=3, N=4
module tb_jt49_dcrm_mc;
    logic       clk, rst_n, cen, din_valid, bypass, flush;
    logic [1:0] din_ch, dout_ch;
    logic [7:0] din;
    logic       din_ready, dout_valid;
    logic [8:0] dout;
    int         errors = 0, checks = 0;

    jt49_dcrm_mc #(.W(8), .CH(3), .DEPTHLOG(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din_valid(din_valid), .din_ch(din_ch),
        .din(din), .bypass(bypass), .flush(flush), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout_ch(dout_ch), .dout(dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one sample from a negedge, optionally stalling cen, and check the result
    task automatic send(int c, int d, bit b, int exp, int gap);
        int lat;
        chk($sformatf("ready ch%0d din%0d", c, d), int'(din_ready), 1);
        din_valid = 1; din_ch = 2'(c); din = 8'(d); bypass = b;
        @(negedge clk);
        din_valid = 0; bypass = 0;
        if (gap > 0) begin
            cen = 0;
            repeat (gap) @(negedge clk);
            chk("cen_hold", int'(din_ready | dout_valid), 0);
            cen = 1;
        end
        lat = 1;
        while (!dout_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency ch%0d din%0d", c, d), lat, 4);
        chk($sformatf("dout ch%0d din%0d", c, d), int'($signed(dout)), exp);
        chk($sformatf("dout_ch ch%0d din%0d", c, d), int'(dout_ch), c);
        @(negedge clk);
        chk("valid_pulse", int'(dout_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n = 0; cen = 1; din_valid = 0; din_ch = 0; din = 0; bypass = 0; flush = 0;
        repeat (2) @(negedge clk);
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        rst_n = 1;
        @(negedge clk);
        chk("pwr_ready", int'(din_ready), 1);
        chk("pwr_dout", int'(dout), 0);
        chk("pwr_valid", int'(dout_valid), 0);

        send(0, 200, 0, 150, 0);
        send(0, 200, 0, 100, 0);
        send(0, 200, 0, 50, 0);
        send(0, 200, 0, 0, 0);
        send(0, 200, 0, 0, 0);
        send(0, 0, 0, -150, 0);

        flush = 1; din_valid = 1; din = 99;
        @(negedge clk);
        flush = 0; din_valid = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("flush_busy%0d", i), int'(din_ready), 0);
            seen |= dout_valid;
            @(negedge clk);
        end
        chk("flush_done", int'(din_ready), 1);
        chk("flush_novalid", int'(seen), 0);
        send(0, 200, 0, 150, 0);

        send(1, 100, 0, 75, 0);
        send(1, 100, 0, 50, 0);
        send(1, 100, 0, 25, 0);
        send(1, 100, 0, 0, 0);
        send(2, 40, 0, 30, 0);
        send(2, 40, 0, 20, 5);

        din_valid = 1; din_ch = 3; din = 77;
        @(negedge clk);
        din_valid = 0;
        seen = 0;
        repeat (6) begin
            seen |= dout_valid;
            @(negedge clk);
        end
        chk("discard_novalid", int'(seen), 0);
        chk("discard_ready", int'(din_ready), 1);
        send(0, 200, 0, 100, 0);

        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst2_dout", int'(dout), 0);
        send(0, 255, 1, 255, 0);
        send(0, 255, 0, 128, 0);

        din_valid = 1; din_ch = 0; din = 200;
        @(negedge clk);
        din_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_dout", int'(dout), 0);
        seen = dout_valid;
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            seen |= dout_valid;
        end
        chk("midrst_novalid", int'(seen), 0);
        chk("midrst_ready", int'(din_ready), 1);
        send(0, 200, 0, 150, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jt49_dcrm_mc.md
JT49_DCRM_MC -- requirements
Module: jt49_dcrm_mc

Interface
REQ-001 SHALL have parameter W, default 8: input sample width, unsigned.
REQ-002 SHALL have parameter CH, default 3: number of time-multiplexed channels, 1..8.
REQ-003 SHALL have parameter DEPTHLOG, default 4: log2 of the moving-average window length N = 2^DEPTHLOG, 1..6.
REQ-004 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port cen, input, 1 bit: clock enable; all state advances only on clk edges with cen=1.
REQ-007 SHALL have port din_valid, input, 1 bit: sample offered.
REQ-008 SHALL have port din_ch, input, max(1,clog2(CH)) bits: channel index of the offered sample.
REQ-009 SHALL have port din, input, W bits: unsigned sample.
REQ-010 SHALL have port bypass, input, 1 bit: output the raw sample instead of the filtered one.
REQ-011 SHALL have port flush, input, 1 bit: clear all filter history.
REQ-012 SHALL have port din_ready, output, 1 bit: block can accept a sample.
REQ-013 SHALL have port dout_valid, output, 1 bit: dout/dout_ch valid.
REQ-014 SHALL have port dout_ch, output, same width as din_ch: channel index of dout.
REQ-015 SHALL have port dout, output, W+1 bits, signed: DC-removed sample.

Function
REQ-016 SHALL implement FSM states IDLE, READ, UPDATE, OUT, FLUSH; transitions occur only on cen=1 edges.
REQ-017 SHALL drive din_ready = 1 only when state is IDLE and flush=0 (combinational).
REQ-018 SHALL accept a sample on a cen edge with din_valid=1 and din_ready=1, registering din, din_ch and bypass; IDLE->READ.
REQ-019 SHALL, when the accepted din_ch >= CH, discard the sample and return to IDLE with no dout_valid.
REQ-020 SHALL keep, per channel, an N-entry history buffer, a write pointer modulo N and a running sum of width W+DEPTHLOG.
REQ-021 SHALL in READ fetch old = history[ch][ptr[ch]]; READ->UPDATE.
REQ-022 SHALL in UPDATE set sum[ch] = sum[ch] + din - old, write din to history[ch][ptr[ch]], and advance ptr[ch] with wrap N-1 -> 0; UPDATE->OUT.
REQ-023 SHALL in OUT, with avg = floor(new sum[ch] / N), register dout = din - avg as a signed W+1-bit value, or dout = din zero-extended when the registered bypass = 1; dout_ch = ch; OUT->IDLE.
REQ-024 SHALL update filter state identically whether bypass is 0 or 1.
REQ-025 SHALL assert dout_valid from the cen edge entering IDLE after OUT until the next cen edge, i.e. for one cen period; the latency from acceptance to dout_valid is 4 cen edges.
REQ-026 SHALL hold dout and dout_ch between updates.
REQ-027 SHALL, when flush=1 in IDLE on a cen edge, enter FLUSH; flush has priority over a simultaneous din_valid, and that sample is not accepted.
REQ-028 SHALL in FLUSH zero one history entry per cen edge, CH*N edges in total, then zero all sums and pointers and return to IDLE.
REQ-029 SHALL ignore flush in any state other than IDLE.
REQ-030 SHALL keep the arithmetic exact: the sum never overflows because it is bounded by N*(2^W-1), and the dout range is -(2^W-1)..(2^W-1).

Reset
REQ-031 SHALL, while rst_n=0 (asynchronous, any state), force state=IDLE, dout=0, dout_ch=0, dout_valid=0, and zero all sums, pointers and history.
REQ-032 SHALL drive din_ready=1 on the first clk after rst_n rises, provided flush=0.
REQ-033 SHALL abandon any in-flight sample on reset without producing output.

Verification (W=8, CH=3, DEPTHLOG=2, N=4)
REQ-034 SHALL cover power-up: reset, then release -> dout=0, dout_valid=0, din_ready=1.
REQ-035 SHALL cover the step response: ch0 din=200 five times -> dout 150, 100, 50, 0, 0, with dout_ch=0 each time.
REQ-036 SHALL cover channel isolation: ch1 din=100 four times, then ch2 din=40 -> ch2 dout=30, unaffected by ch1.
REQ-037 SHALL cover bypass: bypass=1, ch0 din=255 on a fresh filter -> dout=255, and the next ch0 din=255 with bypass=0 -> dout=128.
REQ-038 SHALL cover flush: after the step response, pulse flush with din_valid=1 -> sample not accepted, din_ready=0 for 12 cen edges, then ch0 din=200 -> dout=150.
REQ-039 SHALL cover reset mid-operation: rst_n=0 during UPDATE -> no dout_valid, and after release ch0 din=200 -> dout=150.
